// File: rtl/shift_pkg.sv
// Shared types and direccion codes for the Shifts unit and its operand loader.
`timescale 1ns/1ps
package shift_pkg;

    typedef enum logic [1:0] {
        S_DATA  = 2'd0,
        S_SHIFT = 2'd1,
        S_DIR   = 2'd2,
        S_ISSUE = 2'd3
    } state_e;

    localparam logic [2:0] DIR_SLL = 3'd0;
    localparam logic [2:0] DIR_SRL = 3'd1;
    localparam logic [2:0] DIR_SRA = 3'd2;
    localparam logic [2:0] DIR_ROL = 3'd3;
    localparam logic [2:0] DIR_ROR = 3'd4;
    localparam logic [2:0] DIR_MAX = DIR_ROR;

    // Limit a requested shift amount to the operand width.
    function automatic logic [2:0] clamp_shift(input logic [2:0] amt, input logic [2:0] lim);
        return (amt > lim) ? lim : amt;
    endfunction

endpackage

// File: rtl/btn_cond.sv
// Button conditioner: 2-flop synchronizer, optional debounce, rising-edge pulse.
// Optional debounce enabled by defining BTN_DEBOUNCE_EN.
`timescale 1ns/1ps
module btn_cond
`ifdef BTN_DEBOUNCE_EN
#(
    parameter int unsigned DB_CYCLES = 16
)
`endif
(
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_c
);

    logic [1:0] sync_q, sync_d;
    logic       prev_q, prev_d;
    logic       level;

`ifdef BTN_DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             db_q, db_d;

    // Debounced level follows the synchronized input after DB_CYCLES equal samples.
    always_comb begin
        cnt_d = '0;
        db_d  = db_q;
        if (sync_q[1] != db_q) begin
            if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
                db_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            db_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            db_q  <= db_d;
        end
    end

    assign level = db_q;
`else
    assign level = sync_q[1];
`endif

    always_comb begin
        sync_d = {sync_q[0], btn_i};
        prev_d = level;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign press_c = level & ~prev_q;

endmodule

// File: rtl/shift_operand_loader.sv
// Sequences switch entries into a registered data/shift/direccion set for Shifts.
// Optional button debounce enabled by defining BTN_DEBOUNCE_EN.
`timescale 1ns/1ps
module shift_operand_loader
    import shift_pkg::*;
#(
    parameter int unsigned n = 6
`ifdef BTN_DEBOUNCE_EN
    , parameter int unsigned DB_CYCLES = 16
`endif
)(
    input  logic         clk,
    input  logic         rst,
    input  logic [n-1:0] sw,
    input  logic         btn,
    input  logic         btn_clr,
    output logic [n-1:0] data,
    output logic [2:0]   shift,
    output logic [2:0]   direccion,
    output logic         valid,
    output logic         busy,
    output logic         err,
    output logic [1:0]   state_dbg
);

    localparam logic [2:0] SHIFT_LIM = 3'(n);

    logic press_c;
    logic clr_c;

`ifdef BTN_DEBOUNCE_EN
    btn_cond #(.DB_CYCLES(DB_CYCLES)) u_btn (.clk(clk), .rst(rst), .btn_i(btn),     .press_c(press_c));
    btn_cond #(.DB_CYCLES(DB_CYCLES)) u_clr (.clk(clk), .rst(rst), .btn_i(btn_clr), .press_c(clr_c));
`else
    btn_cond u_btn (.clk(clk), .rst(rst), .btn_i(btn),     .press_c(press_c));
    btn_cond u_clr (.clk(clk), .rst(rst), .btn_i(btn_clr), .press_c(clr_c));
`endif

    state_e       state_q, state_d;
    logic [n-1:0] stage_data_q, stage_data_d;
    logic [2:0]   stage_shift_q, stage_shift_d;
    logic [2:0]   stage_dir_q, stage_dir_d;
    logic [n-1:0] data_q, data_d;
    logic [2:0]   shift_q, shift_d;
    logic [2:0]   dir_q, dir_d;
    logic         valid_q, valid_d;
    logic         err_q, err_d;
    logic         dir_ok;

    assign dir_ok = (sw[2:0] <= DIR_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_DATA;
        end else begin
            state_q <= state_d;
        end
    end

    // Clear overrides any press in the same cycle.
    always_comb begin
        state_d = state_q;
        if (clr_c) begin
            state_d = S_DATA;
        end else begin
            case (state_q)
                S_DATA:  if (press_c) state_d = S_SHIFT;
                S_SHIFT: if (press_c) state_d = S_DIR;
                S_DIR:   if (press_c && dir_ok) state_d = S_ISSUE;
                S_ISSUE: state_d = S_DATA;
                default: state_d = S_DATA;
            endcase
        end
    end

    always_comb begin
        stage_data_d  = stage_data_q;
        stage_shift_d = stage_shift_q;
        stage_dir_d   = stage_dir_q;
        data_d        = data_q;
        shift_d       = shift_q;
        dir_d         = dir_q;
        valid_d       = 1'b0;
        err_d         = err_q;
        if (clr_c) begin
            stage_data_d  = '0;
            stage_shift_d = '0;
            stage_dir_d   = '0;
            err_d         = 1'b0;
        end else begin
            case (state_q)
                S_DATA: if (press_c) begin
                    stage_data_d = sw;
                    err_d        = 1'b0;
                end
                S_SHIFT: if (press_c) begin
                    stage_shift_d = clamp_shift(sw[2:0], SHIFT_LIM);
                    err_d         = 1'b0;
                end
                S_DIR: if (press_c) begin
                    if (dir_ok) begin
                        stage_dir_d = sw[2:0];
                        err_d       = 1'b0;
                    end else begin
                        err_d       = 1'b1;
                    end
                end
                S_ISSUE: begin
                    data_d  = stage_data_q;
                    shift_d = stage_shift_q;
                    dir_d   = stage_dir_q;
                    valid_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_data_q  <= '0;
            stage_shift_q <= '0;
            stage_dir_q   <= '0;
            data_q        <= '0;
            shift_q       <= '0;
            dir_q         <= '0;
            valid_q       <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            stage_data_q  <= stage_data_d;
            stage_shift_q <= stage_shift_d;
            stage_dir_q   <= stage_dir_d;
            data_q        <= data_d;
            shift_q       <= shift_d;
            dir_q         <= dir_d;
            valid_q       <= valid_d;
            err_q         <= err_d;
        end
    end

    assign data      = data_q;
    assign shift     = shift_q;
    assign direccion = dir_q;
    assign valid     = valid_q;
    assign err       = err_q;
    assign busy      = (state_q != S_DATA);
    assign state_dbg = state_q;

endmodule
